// File: rtl/ivs_slv_gen_if.sv
// ----------------------------------------------------------------------------
// ivs_slv_gen_if
// AHB-Lite signal bundle between the interconnect (master side) and the IVS
// configuration slave (slave side).
//
// Signals:
//   hsel       slave select
//   htrans     transfer type (only NONSEQ/SEQ start an access)
//   hwrite     1 = write
//   haddr      byte address, low byte decoded by the slave
//   hwdata     write data, valid in the data phase
//   hsize      transfer size, only word (2'b10) is legal
//   hburst     burst type, not used by the slave
//   hprot      protection bits, not used by the slave
//   hready_in  bus-level ready
//   hready_out slave ready
//   hresp      2'b00 OKAY, 2'b01 ERROR
//   hrdata     read data
// ----------------------------------------------------------------------------
interface ivs_slv_gen_if;
   logic        hsel;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic [1:0]  hsize;
   logic [2:0]  hburst;
   logic [3:0]  hprot;
   logic        hready_in;
   logic        hready_out;
   logic [1:0]  hresp;
   logic [31:0] hrdata;

   modport master (
      output hsel, htrans, hwrite, haddr, hwdata, hsize, hburst, hprot, hready_in,
      input  hready_out, hresp, hrdata
   );

   modport slave (
      input  hsel, htrans, hwrite, haddr, hwdata, hsize, hburst, hprot, hready_in,
      output hready_out, hresp, hrdata
   );
endinterface

// File: rtl/ivs_slv_gen.sv
// ----------------------------------------------------------------------------
// ivs_slv_gen
// AHB-Lite configuration slave for the IVS datapath. Holds N_PAR 32-bit
// config registers, a global control register, a stretchable software reset
// pulse and a read-only status/ID word. Supports programmable wait states,
// an ERROR response for illegal accesses, a config write lock driven by
// glb_ctrl[31], and forwarding of a completing write to a following read.
//
// Ports:
//   hclk_i      clock
//   hrst_i      synchronous active-high reset
//   ahb         AHB-Lite slave port (see ivs_slv_gen_if)
//   cfg_par_o   config registers, register i in bits [32*i+31:32*i]
//   glb_ctrl_o  global control register
//   sw_rst_o    software reset pulse
//   cfg_wr_o    one-cycle update strobe per config register
// ----------------------------------------------------------------------------
module ivs_slv_gen #(
   parameter int          N_PAR     = 8,
   parameter int          WAIT_CYC  = 0,
   parameter int          SWRST_CYC = 4,
   parameter logic [31:0] PAR_RST   = 32'h0,
   parameter logic [15:0] VERSION   = 16'h0002
) (
   input  logic                 hclk_i,
   input  logic                 hrst_i,
   ivs_slv_gen_if.slave         ahb,
   output logic [32*N_PAR-1:0]  cfg_par_o,
   output logic [31:0]          glb_ctrl_o,
   output logic                 sw_rst_o,
   output logic [N_PAR-1:0]     cfg_wr_o
);

   localparam int SW_W = $clog2(SWRST_CYC + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t                  stateQ, stateD;
   logic [2:0]              waitCntQ, waitCntD;
   logic [7:0]              addrQ, addrD;
   logic                    writeQ, writeD;
   logic                    pendQ, pendD;
   logic [31:0]             hrdataQ, hrdataD;
   logic [31:0]             glbCtrlQ, glbCtrlD;
   logic [N_PAR-1:0][31:0]  parQ, parD;
   logic [N_PAR-1:0]        cfgWrQ, cfgWrD;
   logic                    swRstQ, swRstD;
   logic [SW_W-1:0]         swCntQ, swCntD;

   logic        hreadyOut;
   logic        accept;
   logic        complete;
   logic        commit;
   logic [7:0]  offset;
   logic        mapped;
   logic        errNow;
   logic [31:0] rdVal;
   logic [31:0] fwdVal;
   logic [31:0] statusWord;
   logic        wrGlb;
   logic        wrSw;
   logic [N_PAR-1:0] wrPar;
   logic        unusedBits;

   assign unusedBits = ^{ahb.hburst, ahb.hprot, ahb.haddr[31:8]};

   // The slave is ready in IDLE (zero-wait data phase or idle bus) and in the
   // second ERROR cycle, where AHB allows the next address phase to proceed.
   assign hreadyOut      = (stateQ == S_IDLE) || (stateQ == S_ERR2);
   assign ahb.hready_out = hreadyOut;
   assign ahb.hresp      = ((stateQ == S_ERR1) || (stateQ == S_ERR2)) ? 2'b01 : 2'b00;
   assign ahb.hrdata     = hrdataQ;

   assign accept   = ahb.hsel && ahb.htrans[1] && ahb.hready_in && hreadyOut;
   // A pending good transfer finishes its data phase in the first IDLE cycle.
   assign complete = (stateQ == S_IDLE) && pendQ;
   assign commit   = complete && writeQ;
   assign offset   = ahb.haddr[7:0];

   assign statusWord = {VERSION, 8'(N_PAR), 7'b0, glbCtrlQ[31]};

   assign cfg_par_o  = parQ;
   assign glb_ctrl_o = glbCtrlQ;
   assign sw_rst_o   = swRstQ;
   assign cfg_wr_o   = cfgWrQ;

   // Address decode of the incoming address phase: flags whether the offset
   // hits a register and produces that register's current contents.
   always_comb begin
      mapped = 1'b0;
      rdVal  = '0;
      if (offset == 8'h00) begin
         mapped = 1'b1;
         rdVal  = glbCtrlQ;
      end
      if (offset == 8'h04) begin
         mapped = 1'b1;
         rdVal  = {31'b0, swRstQ};
      end
      if (offset == 8'h08) begin
         mapped = 1'b1;
         rdVal  = statusWord;
      end
      for (int i = 0; i < N_PAR; i++) begin
         if (offset == 8'(16 + 4 * i)) begin
            mapped = 1'b1;
            rdVal  = parQ[i];
         end
      end
      errNow = !mapped || (offset[1:0] != 2'b00) || (ahb.hsize != 2'b10);
   end

   // Decode of the write being committed this cycle. Locked config writes
   // still complete with OKAY but touch nothing and raise no strobe.
   always_comb begin
      wrGlb = commit && (addrQ == 8'h00);
      wrSw  = commit && (addrQ == 8'h04) && ahb.hwdata[0];
      wrPar = '0;
      for (int i = 0; i < N_PAR; i++) begin
         wrPar[i] = commit && (addrQ == 8'(16 + 4 * i)) && !glbCtrlQ[31];
      end
   end

   // Read data with forwarding: a read addressing the register that is being
   // written on this same edge sees the new value. A zero written to SWRST
   // changes nothing, so only a start bit is forwarded there.
   always_comb begin
      fwdVal = rdVal;
      if ((wrGlb || (|wrPar)) && (addrQ == offset)) begin
         fwdVal = ahb.hwdata;
      end
      if (wrSw && (offset == 8'h04)) begin
         fwdVal = 32'h1;
      end
   end

   // Next-state logic for the bus FSM and the transfer bookkeeping.
   always_comb begin
      stateD   = stateQ;
      waitCntD = waitCntQ;
      addrD    = addrQ;
      writeD   = writeQ;
      pendD    = pendQ && !complete;
      hrdataD  = hrdataQ;

      if (accept) begin
         addrD  = offset;
         writeD = ahb.hwrite;
         pendD  = !errNow;
         if (!ahb.hwrite) begin
            hrdataD = errNow ? 32'h0 : fwdVal;
         end
      end

      case (stateQ)
         S_IDLE, S_ERR2: begin
            stateD = S_IDLE;
            if (accept) begin
               if (errNow) begin
                  stateD = S_ERR1;
               end else if (WAIT_CYC > 0) begin
                  stateD   = S_WAIT;
                  waitCntD = 3'(WAIT_CYC);
               end
            end
         end
         S_WAIT: begin
            waitCntD = waitCntQ - 3'd1;
            if (waitCntQ <= 3'd1) begin
               stateD = S_IDLE;
            end
         end
         S_ERR1: begin
            stateD = S_ERR2;
         end
         default: begin
            stateD = S_IDLE;
         end
      endcase
   end

   // Register-file updates and the software reset pulse. The pulse counter
   // holds the number of high cycles still to come after the current one, so
   // a fresh start (or a restart while active) reloads SWRST_CYC-1.
   always_comb begin
      glbCtrlD = glbCtrlQ;
      parD     = parQ;
      cfgWrD   = wrPar;
      swRstD   = swRstQ;
      swCntD   = swCntQ;

      if (wrGlb) begin
         glbCtrlD = ahb.hwdata;
      end
      for (int i = 0; i < N_PAR; i++) begin
         if (wrPar[i]) begin
            parD[i] = ahb.hwdata;
         end
      end

      if (wrSw) begin
         swRstD = 1'b1;
         swCntD = SW_W'(SWRST_CYC - 1);
      end else if (swRstQ) begin
         if (swCntQ == '0) begin
            swRstD = 1'b0;
         end else begin
            swCntD = swCntQ - SW_W'(1);
         end
      end
   end

   // State register. Reset drops any transfer in flight, including a write
   // whose data phase has not completed yet.
   always_ff @(posedge hclk_i) begin
      if (hrst_i) begin
         stateQ   <= S_IDLE;
         waitCntQ <= '0;
         addrQ    <= '0;
         writeQ   <= 1'b0;
         pendQ    <= 1'b0;
         hrdataQ  <= '0;
         glbCtrlQ <= '0;
         parQ     <= {N_PAR{PAR_RST}};
         cfgWrQ   <= '0;
         swRstQ   <= 1'b0;
         swCntQ   <= '0;
      end else begin
         stateQ   <= stateD;
         waitCntQ <= waitCntD;
         addrQ    <= addrD;
         writeQ   <= writeD;
         pendQ    <= pendD;
         hrdataQ  <= hrdataD;
         glbCtrlQ <= glbCtrlD;
         parQ     <= parD;
         cfgWrQ   <= cfgWrD;
         swRstQ   <= swRstD;
         swCntQ   <= swCntD;
      end
   end

endmodule
